sha512_compress_ctrl: RTL and testbench

//  Sequencer for the combinational SHA-384/512 round datapath. Accepts one 1024-bit

---
 rtl/sha512_compress_ctrl.sv | 154 +++++++++++++++
 tb/tb_sha512_compress_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/sha512_compress_ctrl.sv
// sha512_compress_ctrl: SHA-384/512 block compression sequencer with RPC stacked rounds per clock
// Ports:
//   clk_i, rst_i (async, active-high)
//   init_i, mode_i        : load chaining value with IV (mode_i=1 -> SHA-384 IV when SHA512_SHA384_IV_EN)
//   blk_valid_i/blk_ready_o, blk_i[1023:0] : block handshake, W0 at [63:0]
//   digest_o[511:0], digest_valid_o : chaining value {H7..H0} and completion flag
//   busy_o                : compression in progress
// Build option: define SHA512_SHA384_IV_EN to enable the SHA-384 IV on mode_i=1.
module sha512_compress_ctrl #(
    parameter int RPC = 1
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          init_i,
    input  logic          mode_i,
    input  logic          blk_valid_i,
    output logic          blk_ready_o,
    input  logic [1023:0] blk_i,
    output logic [511:0]  digest_o,
    output logic          digest_valid_o,
    output logic          busy_o
);
    localparam logic [511:0] IV512 = {
        64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};
    localparam logic [63:0] K [80] = '{
        64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
        64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
        64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
        64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
        64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
        64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
        64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
        64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
        64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
        64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
        64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
        64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
        64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
        64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
        64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
        64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
        64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
        64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
        64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
        64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817};

    typedef enum logic [1:0] {IDLE, RUN, FINAL} state_t;

    state_t         r_fsm, w_nxt;
    logic [6:0]     r_t;
    logic [511:0]   r_chain, r_ws, w_iv;
    logic [1023:0]  r_msg;
    logic           r_dv, w_acc, w_last;

`ifdef SHA512_SHA384_IV_EN
    localparam logic [511:0] IV384 = {
        64'h47b5481dbefa4fa4, 64'hdb0c2e0d64f98fa7, 64'h8eb44a8768581511, 64'h67332667ffc00b31,
        64'h152fecd8f70e5939, 64'h9159015a3070dd17, 64'h629a292a367cd507, 64'hcbbb9d5dc1059ed8};
    assign w_iv = mode_i ? IV384 : IV512;
`else
    logic w_unused;
    assign w_unused = mode_i;
    assign w_iv = IV512;
`endif

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    // state packed {h,g,f,e,d,c,b,a}, a at [63:0] so it lines up with H0
    function automatic logic [511:0] round_f(input logic [511:0] s, input logic [63:0] k, input logic [63:0] w);
        logic [63:0] a, b, c, d, e, f, g, h, t1, t2;
        {h, g, f, e, d, c, b, a} = s;
        t1 = h + (rotr(e, 14) ^ rotr(e, 18) ^ rotr(e, 41)) + ((e & f) ^ (~e & g)) + k + w;
        t2 = (rotr(a, 28) ^ rotr(a, 34) ^ rotr(a, 39)) + ((a & b) ^ (a & c) ^ (b & c));
        return {g, f, e, d + t1, c, b, a, t1 + t2};
    endfunction

    // 16-word sliding window: word 0 is W[t]; append W[t+16] and shift
    function automatic logic [1023:0] sched_f(input logic [1023:0] m);
        logic [63:0] w1, w14;
        w1  = m[127:64];
        w14 = m[959:896];
        return {(rotr(w14, 19) ^ rotr(w14, 61) ^ (w14 >> 6)) + m[639:576]
                + (rotr(w1, 1) ^ rotr(w1, 8) ^ (w1 >> 7)) + m[63:0], m[1023:64]};
    endfunction

    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [511:0]  w_si, w_so;
        logic [1023:0] w_mi, w_mo;
        logic [6:0]    w_ti;
        if (j == 0) begin : g_first
            assign w_si = r_ws;
            assign w_mi = r_msg;
        end else begin : g_next
            assign w_si = g_rnd[j-1].w_so;
            assign w_mi = g_rnd[j-1].w_mo;
        end
        assign w_ti = r_t + 7'(j);
        assign w_so = round_f(w_si, K[w_ti], w_mi[63:0]);
        assign w_mo = sched_f(w_mi);
    end

    assign w_acc  = blk_valid_i & blk_ready_o;
    assign w_last = (r_t + 7'(RPC)) == 7'd80;

    always_ff @(posedge clk_i or posedge rst_i)
        if (rst_i) r_fsm <= IDLE;
        else       r_fsm <= w_nxt;

    always_comb begin
        w_nxt = (r_fsm == IDLE) ? (w_acc ? RUN : IDLE) :
                (r_fsm == RUN)  ? (w_last ? FINAL : RUN) : IDLE;
    end

    always_comb begin
        blk_ready_o = r_fsm == IDLE;
        busy_o      = r_fsm != IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_t     <= '0;
            r_chain <= IV512;
            r_ws    <= '0;
            r_msg   <= '0;
            r_dv    <= 1'b0;
        end else if (r_fsm == IDLE) begin
            if (init_i) begin
                r_chain <= w_iv;
                r_dv    <= 1'b0;
            end
            if (w_acc) begin
                // init in the same cycle compresses from the fresh IV
                r_ws  <= init_i ? w_iv : r_chain;
                r_msg <= blk_i;
                r_t   <= '0;
                r_dv  <= 1'b0;
            end
        end else if (r_fsm == RUN) begin
            r_ws  <= g_rnd[RPC-1].w_so;
            r_msg <= g_rnd[RPC-1].w_mo;
            r_t   <= w_last ? 7'd0 : r_t + 7'(RPC);
        end else begin
            for (int k = 0; k < 8; k++)
                r_chain[64*k +: 64] <= r_chain[64*k +: 64] + r_ws[64*k +: 64];
            r_dv <= 1'b1;
        end
    end

    assign digest_o       = r_chain;
    assign digest_valid_o = r_dv;
endmodule

// File: tb/tb_sha512_compress_ctrl.sv
// tb_sha512_compress_ctrl: directed checks of the SHA-512 compression sequencer (RPC=1 and RPC=4)
module tb_sha512_compress_ctrl;
    localparam logic [511:0] IV512 = {
        64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};
    localparam logic [511:0] D512_ABC = {
        64'h2a9ac94fa54ca49f, 64'h454d4423643ce80e, 64'h36ba3c23a3feebbd, 64'h2192992a274fc1a8,
        64'h0a9eeee64b55d39a, 64'h12e6fa4e89a97ea2, 64'hcc417349ae204131, 64'hddaf35a193617aba};
    localparam logic [511:0] D384_ABC = {128'h0,
        64'h58baeca134c825a7, 64'h8086072ba1e7cc23, 64'h1a8b605a43ff5bed,
        64'h272c32ab0eded163, 64'hb5a03d699ac65007, 64'hcb00753f45a35e8b};
    localparam logic [511:0] D512_2B = {
        64'h5e96e55b874be909, 64'hc7d329eeb6dd2654, 64'h331b99dec4b5433a, 64'h501d289e4900f7e4,
        64'h7299aeadb6889018, 64'h8f7779c6eb9f7fa1, 64'h8cf4f72814fc143f, 64'h8e959b75dae313da};
    localparam logic [511:0] M384 = {128'h0, {384{1'b1}}};

    typedef struct {
        logic          ini_same;
        logic          md;
        int            nblk;
        logic [1023:0] b0;
        logic [1023:0] b1;
        logic [511:0]  exp;
        logic [511:0]  mask;
    } vec_t;

    logic          clk = 0, rst = 1;
    logic          init = 0, mode = 0, bv = 0, rdy, dv, bsy;
    logic [1023:0] blk = '0;
    logic [511:0]  dg;
    logic          init4 = 0, mode4 = 0, bv4 = 0, rdy4, dv4, bsy4;
    logic [1023:0] blk4 = '0;
    logic [511:0]  dg4;
    int            n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    sha512_compress_ctrl #(.RPC(1)) dut (
        .clk_i(clk), .rst_i(rst), .init_i(init), .mode_i(mode), .blk_valid_i(bv),
        .blk_ready_o(rdy), .blk_i(blk), .digest_o(dg), .digest_valid_o(dv), .busy_o(bsy));

    sha512_compress_ctrl #(.RPC(4)) dut4 (
        .clk_i(clk), .rst_i(rst), .init_i(init4), .mode_i(mode4), .blk_valid_i(bv4),
        .blk_ready_o(rdy4), .blk_i(blk4), .digest_o(dg4), .digest_valid_o(dv4), .busy_o(bsy4));

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic [1023:0] abc_blk();
        logic [1023:0] b = '0;
        b[63:0]     = 64'h6162638000000000;
        b[1023:960] = 64'h18;
        return b;
    endfunction

    function automatic logic [1023:0] two_blk0();
        logic [1023:0] b = '0;
        for (int i = 0; i < 14; i++)
            for (int j = 0; j < 8; j++)
                b[64*i + 8*(7-j) +: 8] = 8'(8'h61 + i + j);
        b[64*14 +: 64] = 64'h8000000000000000;
        return b;
    endfunction

    function automatic logic [1023:0] two_blk1();
        logic [1023:0] b = '0;
        b[1023:960] = 64'h380;
        return b;
    endfunction

    task automatic do_init(input logic md);
        init = 1; mode = md;
        @(posedge clk); #1;
        init = 0;
    endtask

    // Offers one block from IDLE, then counts edges after the accept edge until digest_valid_o
    task automatic run_blk(input logic [1023:0] b, input logic ini, input logic md,
                           output int lat, output logic rd_low);
        blk = b; bv = 1; init = ini; mode = md;
        @(posedge clk); #1;
        bv = 0; init = 0;
        lat = 0; rd_low = 1;
        while (!dv && lat < 200) begin
            if (rdy || !bsy) rd_low = 0;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        vec_t vt [4];
        int   lat, n;
        logic rl;
        vt[0] = '{ini_same: 0, md: 0, nblk: 1, b0: abc_blk(), b1: '0, exp: D512_ABC, mask: '1};
        vt[1] = '{ini_same: 0, md: 0, nblk: 2, b0: two_blk0(), b1: two_blk1(), exp: D512_2B, mask: '1};
`ifdef SHA512_SHA384_IV_EN
        vt[2] = '{ini_same: 0, md: 1, nblk: 1, b0: abc_blk(), b1: '0, exp: D384_ABC, mask: M384};
`else
        vt[2] = '{ini_same: 0, md: 1, nblk: 1, b0: abc_blk(), b1: '0, exp: D512_ABC, mask: '1};
`endif
        vt[3] = '{ini_same: 1, md: 0, nblk: 1, b0: abc_blk(), b1: '0, exp: D512_ABC, mask: '1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ready", 512'(rdy), 512'd1);
        chk("rst_busy", 512'(bsy), 512'd0);
        chk("rst_dvalid", 512'(dv), 512'd0);
        chk("rst_digest", dg, IV512);
        rst = 0;
        @(posedge clk); #1;

        do_init(0);
        run_blk(abc_blk(), 0, 0, lat, rl);
        chk("lat_rpc1", 512'(lat), 512'd81);
        chk("ready_low_rpc1", 512'(rl), 512'd1);
        chk("abc_rpc1", dg, D512_ABC);

        init4 = 1; blk4 = abc_blk(); bv4 = 1;
        @(posedge clk); #1;
        init4 = 0; bv4 = 0; lat = 0; rl = 1;
        while (!dv4 && lat < 100) begin
            if (rdy4 || !bsy4) rl = 0;
            @(posedge clk); #1;
            lat++;
        end
        chk("lat_rpc4", 512'(lat), 512'd21);
        chk("ready_low_rpc4", 512'(rl), 512'd1);
        chk("abc_rpc4", dg4, D512_ABC);

        blk = abc_blk(); bv = 1; init = 1; mode = 0;
        @(posedge clk); #1;
        init = 0;
        n = 0;
        while (!dv && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("held_lat", 512'(n), 512'd81);
        chk("held_ready_after_final", 512'(rdy), 512'd1);
        @(posedge clk); #1;
        chk("held_second_accept_busy", 512'(bsy), 512'd1);
        chk("held_second_accept_dv", 512'(dv), 512'd0);
        bv = 0;
        n = 0;
        while (bsy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end

        for (int i = 0; i < 4; i++) begin
            if (!vt[i].ini_same) do_init(vt[i].md);
            run_blk(vt[i].b0, vt[i].ini_same, vt[i].md, lat, rl);
            if (vt[i].nblk == 2) run_blk(vt[i].b1, 0, vt[i].md, lat, rl);
            chk($sformatf("vec%0d_lat", i), 512'(lat), 512'd81);
            chk($sformatf("vec%0d_digest", i), dg & vt[i].mask, vt[i].exp & vt[i].mask);
        end

        do_init(0);
        blk = abc_blk(); bv = 1;
        @(posedge clk); #1;
        bv = 0;
        repeat (40) @(posedge clk);
        #1;
        rst = 1;
        #1;
        chk("abort_dv", 512'(dv), 512'd0);
        chk("abort_ready", 512'(rdy), 512'd1);
        chk("abort_digest", dg, IV512);
        #1;
        rst = 0;
        @(posedge clk); #1;
        chk("abort_dv_after", 512'(dv), 512'd0);
        do_init(0);
        run_blk(abc_blk(), 0, 0, lat, rl);
        chk("abort_lat", 512'(lat), 512'd81);
        chk("abort_digest_new", dg, D512_ABC);

        do_init(0);
        run_blk(two_blk0(), 0, 0, lat, rl);
        blk = two_blk1(); bv = 1;
        @(posedge clk); #1;
        bv = 0;
        repeat (10) @(posedge clk);
        #1;
        init = 1; mode = 0;
        @(posedge clk); #1;
        init = 0;
        n = 0;
        while (!dv && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("init_in_run_dv", 512'(dv), 512'd1);
        chk("init_in_run_digest", dg, D512_2B);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
